// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage of the 16-bit CPU pipeline.
// Holds the 8-entry register file (with write-through), computes immediates
// and the branch target, detects load-use / interlock hazards, generates
// forwarding selects and registers everything into the ID/EX slot.
//
// Handshake: stall_if is a combinational "hold" request to IF. While it is
// high, IF keeps PC and the IF/ID register unchanged and this stage inserts
// a bubble into EX. ex_flush from EX overrides it: the ID instruction is
// squashed and stall_if stays low, so IF moves on to the redirected fetch.
module id_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8,
  parameter int CTRL_W = 16,
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [PC_W-1:0]   if_pc1,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              id_link,
  input  logic              id_use_rn,
  input  logic              id_use_rm,
  input  logic              id_use_rd,
  input  logic              wb_we,
  input  logic [2:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mem_we,
  input  logic [2:0]        mem_rd,
  input  logic              ex_flush,
  output logic              stall_if,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_rn_data,
  output logic [DATA_W-1:0] ex_rm_data,
  output logic [DATA_W-1:0] ex_rd_data,
  output logic [2:0]        ex_rn,
  output logic [2:0]        ex_rm,
  output logic [2:0]        ex_rd,
  output logic              ex_wr_en,
  output logic              ex_is_load,
  output logic [DATA_W-1:0] ex_sximm8,
  output logic [DATA_W-1:0] ex_sximm5,
  output logic [1:0]        ex_alu_op,
  output logic [1:0]        ex_shift,
  output logic [PC_W-1:0]   ex_pc1,
  output logic [PC_W-1:0]   ex_pc_branch,
  output logic [1:0]        ex_fwd_rn,
  output logic [1:0]        ex_fwd_rm,
  output logic [1:0]        ex_fwd_rd
);

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] rn_data;
    logic [DATA_W-1:0] rm_data;
    logic [DATA_W-1:0] rd_data;
    logic [2:0]        rn;
    logic [2:0]        rm;
    logic [2:0]        rd;
    logic              wr_en;
    logic              is_load;
    logic [DATA_W-1:0] sximm8;
    logic [DATA_W-1:0] sximm5;
    logic [1:0]        alu_op;
    logic [1:0]        shift;
    logic [PC_W-1:0]   pc1;
    logic [PC_W-1:0]   pc_branch;
    logic [1:0]        fwd_rn;
    logic [1:0]        fwd_rm;
    logic [1:0]        fwd_rd;
  } ex_reg_t;

  logic [DATA_W-1:0] rf_q [8];
  logic [DATA_W-1:0] rf_d [8];
  ex_reg_t           ex_q, ex_d;

  logic [2:0]        rn_idx, rm_idx, rd_idx, dest_idx;
  logic [DATA_W-1:0] rn_data, rm_data, rd_data;
  logic [DATA_W-1:0] sximm8, sximm5;
  logic [PC_W-1:0]   pc_branch;
  logic [2:0]        src_idx [3];
  logic [2:0]        src_use;
  logic [2:0]        ex_hit, mem_hit;
  logic [1:0]        fwd_sel [3];
  logic              hazard, stall_raw;

  // Opcode bits are consumed by the control unit, not by this stage.
  logic unused_opcode;
  assign unused_opcode = ^if_instr[15:13];

  assign rn_idx   = if_instr[10:8];
  assign rm_idx   = if_instr[2:0];
  assign rd_idx   = if_instr[7:5];
  assign dest_idx = id_link ? 3'd7 : rd_idx;

  // Write-through: a same-cycle WB write to the read index wins over the array.
  assign rn_data = (wb_we && wb_reg == rn_idx) ? wb_data : rf_q[rn_idx];
  assign rm_data = (wb_we && wb_reg == rm_idx) ? wb_data : rf_q[rm_idx];
  assign rd_data = (wb_we && wb_reg == rd_idx) ? wb_data : rf_q[rd_idx];

  assign sximm8    = DATA_W'($signed(if_instr[7:0]));
  assign sximm5    = DATA_W'($signed(if_instr[4:0]));
  assign pc_branch = if_pc1 + PC_W'($signed(if_instr[7:0]));

  // Register file next state: one write port from WB.
  always_comb begin
    rf_d = rf_q;
    if (wb_we) rf_d[wb_reg] = wb_data;
  end

  // Register file storage, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Source matching against EX and MEM destinations; hazard and forward selects.
  always_comb begin
    src_idx[0] = rn_idx;
    src_idx[1] = rm_idx;
    src_idx[2] = rd_idx;
    src_use    = {id_use_rd, id_use_rm, id_use_rn};
    ex_hit     = '0;
    mem_hit    = '0;
    for (int i = 0; i < 3; i++) begin
      ex_hit[i]  = src_use[i] & ex_q.valid & ex_q.wr_en & (ex_q.rd == src_idx[i]);
      mem_hit[i] = src_use[i] & mem_we & (mem_rd == src_idx[i]);
      fwd_sel[i] = 2'd0;
      if (FWD_EN != 0) begin
        if (ex_hit[i])       fwd_sel[i] = 2'd1;
        else if (mem_hit[i]) fwd_sel[i] = 2'd2;
      end
    end
    if (FWD_EN != 0) hazard = ex_q.is_load & (|ex_hit);
    else             hazard = (|ex_hit) | (|mem_hit);
  end

  assign stall_raw = if_valid & hazard;
  assign stall_if  = stall_raw & ~ex_flush & rst_n;

  // ID/EX next state: flush or stall insert a bubble, otherwise capture decode.
  always_comb begin
    ex_d = ex_q;
    if (ex_flush || stall_raw) begin
      ex_d.valid   = 1'b0;
      ex_d.wr_en   = 1'b0;
      ex_d.is_load = 1'b0;
      ex_d.ctrl    = '0;
    end else begin
      ex_d.valid     = if_valid;
      ex_d.ctrl      = id_ctrl;
      ex_d.rn_data   = rn_data;
      ex_d.rm_data   = rm_data;
      ex_d.rd_data   = rd_data;
      ex_d.rn        = rn_idx;
      ex_d.rm        = rm_idx;
      ex_d.rd        = dest_idx;
      ex_d.wr_en     = id_wr_en & if_valid;
      ex_d.is_load   = id_is_load & if_valid;
      ex_d.sximm8    = sximm8;
      ex_d.sximm5    = sximm5;
      ex_d.alu_op    = if_instr[12:11];
      ex_d.shift     = if_instr[4:3];
      ex_d.pc1       = if_pc1;
      ex_d.pc_branch = pc_branch;
      ex_d.fwd_rn    = fwd_sel[0];
      ex_d.fwd_rm    = fwd_sel[1];
      ex_d.fwd_rd    = fwd_sel[2];
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign ex_valid     = ex_q.valid;
  assign ex_ctrl      = ex_q.ctrl;
  assign ex_rn_data   = ex_q.rn_data;
  assign ex_rm_data   = ex_q.rm_data;
  assign ex_rd_data   = ex_q.rd_data;
  assign ex_rn        = ex_q.rn;
  assign ex_rm        = ex_q.rm;
  assign ex_rd        = ex_q.rd;
  assign ex_wr_en     = ex_q.wr_en;
  assign ex_is_load   = ex_q.is_load;
  assign ex_sximm8    = ex_q.sximm8;
  assign ex_sximm5    = ex_q.sximm5;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_shift     = ex_q.shift;
  assign ex_pc1       = ex_q.pc1;
  assign ex_pc_branch = ex_q.pc_branch;
  assign ex_fwd_rn    = ex_q.fwd_rn;
  assign ex_fwd_rm    = ex_q.fwd_rm;
  assign ex_fwd_rd    = ex_q.fwd_rd;

endmodule
